// File: rtl/move_enable_decoder.sv
// move_enable_decoder
// Registered cell-enable decoder for the tic-tac-toe board. Takes one move
// per handshake, validates range and occupancy, drives a one-hot write
// enable toward the cell storage and keeps the occupancy map.
//
// state | meaning
// IDLE  | ready for a move
// ISSUE | one-cycle result cycle (accept/reject pulse visible)
// FULL  | board full, waiting for clear or rst

module move_enable_decoder #(
    parameter int NUM_CELLS  = 9,
    parameter int SEL_W      = 4,
    parameter int PULSE_MODE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_move_valid,
    input  logic [SEL_W-1:0]     i_move_sel,
    input  logic                 i_move_player,
    output logic                 o_move_ready,
    output logic [NUM_CELLS-1:0] o_cell_en,
    output logic                 o_cell_player,
    output logic                 o_move_accept,
    output logic                 o_move_reject,
    output logic [NUM_CELLS-1:0] o_occupied,
    output logic                 o_board_full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               r_state;
    logic [NUM_CELLS-1:0] r_cell_en;
    logic                 r_cell_player;
    logic                 r_move_accept;
    logic                 r_move_reject;
    logic [NUM_CELLS-1:0] r_occupied;
    logic                 r_board_full;

    logic [NUM_CELLS-1:0] w_sel_onehot;
    logic [NUM_CELLS-1:0] w_occ_next;
    logic                 w_legal;
    logic                 w_transfer;

    // Decode the requested index; out-of-range indices match no bit.
    always_comb begin
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            w_sel_onehot[i] = (i_move_sel == SEL_W'(i));
        end
        w_legal    = (|w_sel_onehot) && !(|(w_sel_onehot & r_occupied));
        w_occ_next = r_occupied | w_sel_onehot;
    end

    assign o_move_ready = (r_state == IDLE) && !i_clear;
    assign w_transfer   = i_move_valid && o_move_ready;

    // Move FSM with registered result outputs and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cell_en     <= '0;
            r_cell_player <= 1'b0;
            r_move_accept <= 1'b0;
            r_move_reject <= 1'b0;
            r_occupied    <= '0;
            r_board_full  <= 1'b0;
        end else if (i_clear) begin
            r_state       <= IDLE;
            r_cell_en     <= '0;
            r_move_accept <= 1'b0;
            r_move_reject <= 1'b0;
            r_occupied    <= '0;
            r_board_full  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        r_state <= ISSUE;
                        if (w_legal) begin
                            r_cell_en     <= w_sel_onehot;
                            r_cell_player <= i_move_player;
                            r_occupied    <= w_occ_next;
                            r_board_full  <= &w_occ_next;
                            r_move_accept <= 1'b1;
                        end else begin
                            r_move_reject <= 1'b1;
                            if (PULSE_MODE != 0) begin
                                r_cell_en <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    r_move_accept <= 1'b0;
                    r_move_reject <= 1'b0;
                    if (PULSE_MODE != 0) begin
                        r_cell_en <= '0;
                    end
                    r_state <= r_board_full ? FULL : IDLE;
                end
                FULL: begin
                    r_state <= FULL;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_cell_en     = r_cell_en;
    assign o_cell_player = r_cell_player;
    assign o_move_accept = r_move_accept;
    assign o_move_reject = r_move_reject;
    assign o_occupied    = r_occupied;
    assign o_board_full  = r_board_full;

endmodule

// File: tb/tb_move_enable_decoder.sv
// Bench for move_enable_decoder: one pulse-mode and one hold-mode instance
// share stimulus; each is compared against a board-level reference model.

module tb_move_enable_decoder;

    localparam int N = 9;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, clr, mv, mp;
    logic [W-1:0] ms;

    logic         rdy   [2];
    logic [N-1:0] en    [2];
    logic         pl    [2];
    logic         acc   [2];
    logic         rej   [2];
    logic [N-1:0] occ   [2];
    logic         full  [2];

    // Reference model state, index 0 = hold mode, 1 = pulse mode.
    logic [N-1:0] m_occ [2];
    logic [N-1:0] m_en  [2];
    logic         m_pl  [2];
    logic         m_acc [2];
    logic         m_rej [2];
    logic         m_full[2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    move_enable_decoder #(.NUM_CELLS(N), .SEL_W(W), .PULSE_MODE(0)) u_hold (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_move_valid(mv),
        .i_move_sel(ms), .i_move_player(mp), .o_move_ready(rdy[0]),
        .o_cell_en(en[0]), .o_cell_player(pl[0]), .o_move_accept(acc[0]),
        .o_move_reject(rej[0]), .o_occupied(occ[0]), .o_board_full(full[0]));

    move_enable_decoder #(.NUM_CELLS(N), .SEL_W(W), .PULSE_MODE(1)) u_pulse (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_move_valid(mv),
        .i_move_sel(ms), .i_move_player(mp), .o_move_ready(rdy[1]),
        .o_cell_en(en[1]), .o_cell_player(pl[1]), .o_move_accept(acc[1]),
        .o_move_reject(rej[1]), .o_occupied(occ[1]), .o_board_full(full[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A move can be taken when no result is showing, the board is not
    // full and no clear is requested.
    function automatic logic model_ready(input int m);
        return !(m_acc[m] || m_rej[m]) && !m_full[m] && !clr;
    endfunction

    task automatic model_step(input int m, input logic take);
        if (rst) begin
            m_occ[m] = '0; m_en[m] = '0; m_pl[m] = 1'b0;
            m_acc[m] = 1'b0; m_rej[m] = 1'b0; m_full[m] = 1'b0;
        end else if (clr) begin
            m_occ[m] = '0; m_en[m] = '0;
            m_acc[m] = 1'b0; m_rej[m] = 1'b0; m_full[m] = 1'b0;
        end else if (m_acc[m] || m_rej[m]) begin
            m_acc[m] = 1'b0; m_rej[m] = 1'b0;
            if (m == 1) m_en[m] = '0;
        end else if (take) begin
            if (int'(ms) < N && !m_occ[m][ms]) begin
                m_en[m]  = N'(1) << ms;
                m_occ[m] = m_occ[m] | m_en[m];
                m_pl[m]  = mp;
                m_acc[m] = 1'b1;
                m_full[m] = (m_occ[m] == {N{1'b1}});
            end else begin
                m_rej[m] = 1'b1;
                if (m == 1) m_en[m] = '0;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic v,
                         input int s, input logic p);
        logic take [2];
        @(negedge clk);
        rst = r; clr = c; mv = v; ms = W'(s); mp = p;
        #1;
        for (int m = 0; m < 2; m++) begin
            take[m] = v && model_ready(m);
            chk($sformatf("ready[%0d]", m), 32'(rdy[m]), 32'(model_ready(m)));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, take[m]);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("cell_en[%0d]", m), 32'(en[m]), 32'(m_en[m]));
            chk($sformatf("player[%0d]", m), 32'(pl[m]), 32'(m_pl[m]));
            chk($sformatf("accept[%0d]", m), 32'(acc[m]), 32'(m_acc[m]));
            chk($sformatf("reject[%0d]", m), 32'(rej[m]), 32'(m_rej[m]));
            chk($sformatf("occupied[%0d]", m), 32'(occ[m]), 32'(m_occ[m]));
            chk($sformatf("full[%0d]", m), 32'(full[m]), 32'(m_full[m]));
        end
    endtask

    task automatic move(input int s, input logic p);
        cycle(1'b0, 1'b0, 1'b1, s, p);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; mv = 1'b0; ms = '0; mp = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_occ[m] = '0; m_en[m] = '0; m_pl[m] = 1'b0;
            m_acc[m] = 1'b0; m_rej[m] = 1'b0; m_full[m] = 1'b0;
        end
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Accept, occupied reject, out-of-range rejects.
        move(4, 1'b0);
        move(4, 1'b1);
        move(9, 1'b0);
        move(15, 1'b1);

        // Fill the board, holding valid through each result cycle.
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b0, 1'b1, i, 1'(i));
            cycle(1'b0, 1'b0, 1'b1, i, 1'(i));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, i * 3, 1'b1);

        // Clear with a simultaneous move, then the move goes through.
        cycle(1'b0, 1'b1, 1'b1, 0, 1'b0);
        move(0, 1'b1);

        // Hold-mode sequence: accept 2, reject 2, accept 7.
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
        move(2, 1'b0);
        move(2, 1'b1);
        move(7, 1'b1);

        // rst together with clear in the result cycle, then re-issue.
        cycle(1'b0, 1'b0, 1'b1, 5, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
        move(5, 1'b1);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic r, c, v, p;
            int s;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, N - 1);
            p = 1'($urandom);
            cycle(r, c, v, s, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
